reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 72 +++++++
 rtl/reg_file_sb.sv | 86 ++++++++
 tb/tb_reg_file_sb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared defaults and address-width helper for the register file
package reg_file_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits, reservation handshake and busy count
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NWR-1:0]           i_wr_en,
  input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
  input  logic                     i_iss_valid,
  input  logic [AW-1:0]            i_iss_rd,
  output logic [NREGS-1:0]         o_busy,
  output logic                     o_iss_ready,
  output logic [AW:0]              o_busy_cnt
);

  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;
  logic [NREGS-1:0] w_wr_dec [NWR];
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_iss_ok;

  genvar w;
  for (w = 0; w < NWR; w++) begin : g_wr_dec
    assign w_wr_dec[w] = i_wr_en[w] ? ({{(NREGS-1){1'b0}}, 1'b1} << i_wr_addr[w]) : '0;
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NWR; i++) begin
      w_clr = w_clr | w_wr_dec[i];
    end
  end

  // A register being released this cycle may be re-reserved in the same cycle.
  assign w_iss_ok = i_iss_valid && !reset && !(ZERO_REG && (i_iss_rd == '0)) &&
                    (!r_busy[i_iss_rd] || w_clr[i_iss_rd]);
  assign w_set    = w_iss_ok ? ({{(NREGS-1){1'b0}}, 1'b1} << i_iss_rd) : '0;

  always_comb begin
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
    if (ZERO_REG) begin
      w_busy_nxt[0] = 1'b0;
    end
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_iss_ready = w_iss_ok;
  assign o_busy_cnt  = r_busy_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write bypass and reservation scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   i_rd_addr,
  output logic [NRD-1:0][XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]           o_rd_busy,
  input  logic [NWR-1:0]           i_wr_en,
  input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] i_wr_data,
  input  logic                     i_iss_valid,
  input  logic [AW-1:0]            i_iss_rd,
  output logic                     o_iss_ready,
  output logic [AW:0]              o_busy_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;

  // Later ports are applied last, so the highest-index port wins a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (i_wr_en[i] && !(ZERO_REG && (i_wr_addr[i] == '0))) begin
          r_regs[i_wr_addr[i]] <= i_wr_data[i];
        end
      end
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .o_busy      (w_busy),
    .o_iss_ready (o_iss_ready),
    .o_busy_cnt  (o_busy_cnt)
  );

  genvar p;
  for (p = 0; p < NRD; p++) begin : g_rd
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;
    logic            w_zero;
    logic            w_byp;

    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int i = 0; i < NWR; i++) begin
        if (i_wr_en[i] && (i_wr_addr[i] == i_rd_addr[p])) begin
          w_hit = 1'b1;
          w_fwd = i_wr_data[i];
        end
      end
    end

    // Forwarding is suppressed under reset so every read returns zero immediately.
    assign w_zero       = ZERO_REG && (i_rd_addr[p] == '0);
    assign w_byp        = BYPASS && w_hit && !reset;
    assign o_rd_data[p] = w_zero ? '0 : (w_byp ? w_fwd : r_regs[i_rd_addr[p]]);
    assign o_rd_busy[p] = !w_zero && !w_byp && w_busy[i_rd_addr[p]];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard-driven self-checking bench for reg_file_sb
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = calc_aw(NREGS);

  logic                     clk;
  logic                     reset;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic [AW:0]              busy_cnt;

  reg_file_sb #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_busy   (rd_busy),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .o_busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NRD-1:0][XLEN-1:0] d;
    logic [NRD-1:0]           b;
    logic                     rdy;
    logic [AW:0]              cnt;
  } exp_t;

  exp_t             exp_q[$];
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  logic [AW:0]      m_cnt;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    logic [AW-1:0] a;
    logic clearing;
    e = '0;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p];
      e.d[p] = m_regs[a];
      e.b[p] = m_busy[a];
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w] == a) begin
          e.d[p] = wr_data[w];
          e.b[p] = 1'b0;
        end
      end
      if (a == '0) begin
        e.d[p] = '0;
        e.b[p] = 1'b0;
      end
    end
    clearing = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w] == iss_rd) clearing = 1'b1;
    end
    e.rdy = iss_valid && (iss_rd != '0) && (!m_busy[iss_rd] || clearing);
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic model_update();
    exp_t e;
    e = model_exp();
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w] != '0) m_regs[wr_addr[w]] = wr_data[w];
    end
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) m_busy[wr_addr[w]] = 1'b0;
    end
    if (e.rdy) m_busy[iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
    m_cnt = (AW+1)'($countones(m_busy));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
    m_cnt  = '0;
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("rd_data%0d", p), 64'(rd_data[p]), 64'(e.d[p]));
      end
      chk("rd_busy", 64'(rd_busy), 64'(e.b));
      chk("iss_ready", 64'(iss_ready), 64'(e.rdy));
      chk("busy_cnt", 64'(busy_cnt), 64'(e.cnt));
    end
  endtask

  task automatic cycle();
    exp_q.push_back(model_exp());
    #2;
    compare_out();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  initial begin
    idle();
    model_reset();
    reset      = 1'b1;
    wr_en      = 2'b11;
    wr_addr[0] = AW'(5);
    wr_addr[1] = AW'(3);
    wr_data[0] = 32'h1234_5678;
    wr_data[1] = 32'h9ABC_DEF0;
    iss_valid  = 1'b1;
    iss_rd     = AW'(3);
    rd_addr[0] = AW'(5);
    rd_addr[1] = AW'(3);
    rd_addr[2] = AW'(5);
    #2;
    exp_q.push_back('0);
    compare_out();
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    compare_out();
    @(negedge clk);
    reset = 1'b0;
    idle();
    rd_addr[0] = AW'(5);
    rd_addr[1] = AW'(3);
    cycle();

    wr_en[0]   = 1'b1;
    wr_addr[0] = AW'(5);
    wr_data[0] = 32'hDEAD_BEEF;
    cycle();
    idle();
    rd_addr[1] = AW'(5);
    #1 chk("r5_read", 64'(rd_data[1]), 64'(32'hDEAD_BEEF));
    cycle();

    wr_en      = 2'b11;
    wr_addr[0] = AW'(7);
    wr_addr[1] = AW'(7);
    wr_data[0] = 32'h11;
    wr_data[1] = 32'h22;
    rd_addr[0] = AW'(7);
    #1 chk("r7_bypass", 64'(rd_data[0]), 64'(32'h22));
    cycle();
    idle();
    rd_addr[2] = AW'(7);
    #1 chk("r7_read", 64'(rd_data[2]), 64'(32'h22));
    cycle();

    wr_en[1]   = 1'b1;
    wr_addr[1] = '0;
    wr_data[1] = 32'hFFFF_FFFF;
    iss_valid  = 1'b1;
    iss_rd     = '0;
    #1 chk("r0_bypass", 64'(rd_data[0]), 64'(0));
    chk("r0_iss", 64'(iss_ready), 64'(0));
    cycle();
    idle();
    #1 chk("r0_read", 64'(rd_data[0]), 64'(0));
    chk("r0_cnt", 64'(busy_cnt), 64'(0));
    cycle();

    iss_valid = 1'b1;
    iss_rd    = AW'(3);
    #1 chk("r3_iss", 64'(iss_ready), 64'(1));
    cycle();
    rd_addr[0] = AW'(3);
    #1 chk("r3_cnt", 64'(busy_cnt), 64'(1));
    chk("r3_busy", 64'(rd_busy[0]), 64'(1));
    chk("r3_reiss", 64'(iss_ready), 64'(0));
    cycle();
    wr_en[0]   = 1'b1;
    wr_addr[0] = AW'(3);
    wr_data[0] = 32'h33;
    rd_addr[1] = AW'(3);
    #1 chk("r3_wr_iss", 64'(iss_ready), 64'(1));
    chk("r3_byp_busy", 64'(rd_busy[1]), 64'(0));
    cycle();
    idle();
    rd_addr[0] = AW'(3);
    #1 chk("r3_still_busy", 64'(rd_busy[0]), 64'(1));
    chk("r3_cnt_after", 64'(busy_cnt), 64'(1));
    cycle();

    for (int r = 1; r <= 4; r++) begin
      idle();
      iss_valid = 1'b1;
      iss_rd    = AW'(r);
      cycle();
    end
    idle();
    rd_addr[0] = AW'(1);
    rd_addr[1] = AW'(2);
    rd_addr[2] = AW'(4);
    wr_en[0]   = 1'b1;
    wr_addr[0] = AW'(2);
    wr_data[0] = 32'hAA;
    iss_valid  = 1'b1;
    iss_rd     = AW'(5);
    #1 chk("cnt_before_reset", 64'(busy_cnt), 64'(4));
    reset = 1'b1;
    #1;
    exp_q.push_back('0);
    compare_out();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    cycle();

    for (int n = 0; n < 10000; n++) begin
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) == 0);
        wr_addr[w] = AW'($urandom_range(0, NREGS-1));
        wr_data[w] = XLEN'($urandom);
      end
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 2) == 0) rd_addr[p] = wr_addr[$urandom_range(0, NWR-1)];
        else rd_addr[p] = AW'($urandom_range(0, NREGS-1));
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom_range(0, NREGS-1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
